// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line engine: receives and checks 48-bit host commands, hands them
// to a back-end, then serializes the back-end's R1/R7-style or R2-style response after NCR.
module sd_card_cmd_responder #(
  parameter int NCR_CYCLES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clk_en_p_i,
  input  logic         clk_en_n_i,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_en_o,
  output logic         cmd_valid_o,
  input  logic         cmd_ready_i,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_crc_err_o,
  output logic         cmd_frame_err_o,
  input  logic         rsp_valid_i,
  output logic         rsp_ready_o,
  input  logic [1:0]   rsp_type_i,
  input  logic         rsp_crc_en_i,
  input  logic [5:0]   rsp_index_i,
  input  logic [119:0] rsp_data_i
);

  localparam logic [6:0] LP_NCR = 7'(NCR_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_CMD_OUT, S_WAIT_RSP, S_NCR, S_TX
  } state_t;

  state_t r_state, w_next;

  logic [45:0]  r_rx_sr;
  logic [5:0]   r_rx_idx;
  logic [6:0]   r_crc;
  logic [5:0]   r_cmd_index;
  logic [31:0]  r_cmd_arg;
  logic         r_crc_err;
  logic         r_frame_err;
  logic [6:0]   r_ncr;
  logic [135:0] r_tx_sr;
  logic [7:0]   r_tx_cnt;
  logic         r_sd_cmd;
  logic         r_sd_cmd_en;

  logic [46:0]  w_frame;
  logic         w_eval;
  logic         w_frame_bad;
  logic         w_crc_bad;
  logic         w_rsp_go;
  logic [39:0]  w_short_msg;
  logic [6:0]   w_crc_short;
  logic [6:0]   w_crc_long;
  logic [47:0]  w_short_frame;
  logic [135:0] w_long_frame;

  // CRC7, polynomial x^7 + x^3 + 1, one bit per call
  function automatic logic [6:0] f_crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Receive path: w_frame is bit46..bit0 once the end bit is on the line
  assign w_frame     = {r_rx_sr, sd_cmd_i};
  assign w_eval      = (r_state == S_RX) && clk_en_p_i && (r_rx_idx == 6'd0);
  assign w_frame_bad = !w_frame[46] || !w_frame[0];
  assign w_crc_bad   = (w_frame[7:1] != r_crc);
  assign w_rsp_go    = (r_state == S_WAIT_RSP) && rsp_valid_i &&
                       ((rsp_type_i == 2'd1) || (rsp_type_i == 2'd2));

  // Response frames are assembled whole at handshake time
  assign w_short_msg = {2'b00, rsp_index_i, rsp_data_i[31:0]};

  always_comb begin
    w_crc_short = '0;
    w_crc_long  = '0;
    for (int i = 39; i >= 0; i--)
      w_crc_short = f_crc7_step(w_crc_short, w_short_msg[i]);
    for (int i = 119; i >= 0; i--)
      w_crc_long = f_crc7_step(w_crc_long, rsp_data_i[i]);
  end

  assign w_short_frame = {w_short_msg, (rsp_crc_en_i ? w_crc_short : 7'h7F), 1'b1};
  assign w_long_frame  = {2'b00, 6'h3F, rsp_data_i, (rsp_crc_en_i ? w_crc_long : 7'h7F), 1'b1};

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (clk_en_p_i && !sd_cmd_i) w_next = S_RX;
      S_RX:       if (w_eval) w_next = (w_frame_bad || w_crc_bad) ? S_IDLE : S_CMD_OUT;
      S_CMD_OUT:  if (cmd_ready_i) w_next = S_WAIT_RSP;
      S_WAIT_RSP: if (rsp_valid_i) w_next = w_rsp_go ? S_NCR : S_IDLE;
      S_NCR:      if (r_ncr == 7'd0) w_next = S_TX;
      S_TX:       if (clk_en_n_i && (r_tx_cnt == 8'd0)) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_sr     <= '0;
      r_rx_idx    <= '0;
      r_crc       <= '0;
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_ncr       <= '0;
      r_tx_sr     <= '0;
      r_tx_cnt    <= '0;
      r_sd_cmd    <= 1'b1;
      r_sd_cmd_en <= 1'b0;
    end else begin
      // a frame error masks a CRC error on the same frame
      r_crc_err   <= w_eval && !w_frame_bad && w_crc_bad;
      r_frame_err <= w_eval && w_frame_bad;

      if ((r_state == S_IDLE) && clk_en_p_i && !sd_cmd_i) begin
        r_rx_idx <= 6'd46;
        r_crc    <= '0;
      end
      if ((r_state == S_RX) && clk_en_p_i) begin
        r_rx_sr <= {r_rx_sr[44:0], sd_cmd_i};
        if (r_rx_idx >= 6'd8) r_crc <= f_crc7_step(r_crc, sd_cmd_i);
        if (r_rx_idx != 6'd0) r_rx_idx <= r_rx_idx - 6'd1;
      end
      if (w_eval && !w_frame_bad && !w_crc_bad) begin
        r_cmd_index <= w_frame[45:40];
        r_cmd_arg   <= w_frame[39:8];
      end

      if (w_rsp_go) begin
        r_ncr <= LP_NCR;
        if (rsp_type_i == 2'd1) begin
          r_tx_sr  <= {w_short_frame, 88'd0};
          r_tx_cnt <= 8'd48;
        end else begin
          r_tx_sr  <= w_long_frame;
          r_tx_cnt <= 8'd136;
        end
      end else if ((r_state == S_NCR) && clk_en_p_i && (r_ncr != 7'd0)) begin
        r_ncr <= r_ncr - 7'd1;
      end

      // one bit per sd_clk negedge; the enable after the end bit releases the line
      if ((r_state == S_TX) && clk_en_n_i) begin
        if (r_tx_cnt != 8'd0) begin
          r_sd_cmd    <= r_tx_sr[135];
          r_sd_cmd_en <= 1'b1;
          r_tx_sr     <= {r_tx_sr[134:0], 1'b0};
          r_tx_cnt    <= r_tx_cnt - 8'd1;
        end else begin
          r_sd_cmd    <= 1'b1;
          r_sd_cmd_en <= 1'b0;
        end
      end
    end
  end

  assign sd_cmd_o        = r_sd_cmd;
  assign sd_cmd_en_o     = r_sd_cmd_en;
  assign cmd_valid_o     = (r_state == S_CMD_OUT);
  assign rsp_ready_o     = (r_state == S_WAIT_RSP);
  assign cmd_index_o     = r_cmd_index;
  assign cmd_arg_o       = r_cmd_arg;
  assign cmd_crc_err_o   = r_crc_err;
  assign cmd_frame_err_o = r_frame_err;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench: host frames and back-end responses are driven with expectations
// queued from a reference model; a negedge monitor pops and compares DUT events.
module tb_sd_card_cmd_responder;
  localparam int NCR = 2;
  localparam int K_CMD = 0, K_CRC = 1, K_FRM = 2, K_RSP = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         clk_en_p_i, clk_en_n_i;
  logic         sd_cmd_i;
  logic         sd_cmd_o, sd_cmd_en_o;
  logic         cmd_valid_o, cmd_ready_i;
  logic [5:0]   cmd_index_o;
  logic [31:0]  cmd_arg_o;
  logic         cmd_crc_err_o, cmd_frame_err_o;
  logic         rsp_valid_i, rsp_ready_o;
  logic [1:0]   rsp_type_i;
  logic         rsp_crc_en_i;
  logic [5:0]   rsp_index_i;
  logic [119:0] rsp_data_i;

  sd_card_cmd_responder #(.NCR_CYCLES(NCR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_p_i(clk_en_p_i), .clk_en_n_i(clk_en_n_i),
    .sd_cmd_i(sd_cmd_i), .sd_cmd_o(sd_cmd_o), .sd_cmd_en_o(sd_cmd_en_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_index_o(cmd_index_o),
    .cmd_arg_o(cmd_arg_o), .cmd_crc_err_o(cmd_crc_err_o), .cmd_frame_err_o(cmd_frame_err_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_type_i(rsp_type_i),
    .rsp_crc_en_i(rsp_crc_en_i), .rsp_index_i(rsp_index_i), .rsp_data_i(rsp_data_i)
  );

  always #5 clk_i = ~clk_i;

  // sd_clk = clk_i/4: posedge enable in phase 0, negedge enable in phase 2
  logic [1:0] phase = 2'd0;
  always @(posedge clk_i) phase <= phase + 2'd1;
  assign clk_en_p_i = (phase == 2'd0);
  assign clk_en_n_i = (phase == 2'd2);

  typedef struct {
    int           kind;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [135:0] bits;
    int           len;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s timeout", nm);
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division)
  function automatic logic [6:0] ref_crc(input logic [127:0] msg, input int n);
    logic [134:0] r;
    r = {msg, 7'b0};
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.kind = K_CMD; e.idx = '0; e.arg = '0; e.bits = '0; e.len = 0;
    return e;
  endfunction

  function automatic exp_t host_expect(input logic [47:0] f);
    exp_t e;
    e = blank();
    if (!f[46] || !f[0])                                  e.kind = K_FRM;
    else if (f[7:1] != ref_crc({88'd0, f[47:8]}, 40))     e.kind = K_CRC;
    else begin
      e.kind = K_CMD; e.idx = f[45:40]; e.arg = f[39:8];
    end
    return e;
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, ref_crc({88'd0, m}, 40), 1'b1};
  endfunction

  function automatic exp_t rsp_expect(input logic [1:0] t, input logic ce,
                                      input logic [5:0] idx, input logic [119:0] d);
    exp_t e;
    logic [39:0] m;
    logic [6:0]  c;
    e = blank();
    e.kind = K_RSP;
    if (t == 2'd1) begin
      m = {2'b00, idx, d[31:0]};
      c = ce ? ref_crc({88'd0, m}, 40) : 7'h7F;
      e.bits = {m, c, 1'b1, 88'd0};
      e.len  = 48;
    end else begin
      c = ce ? ref_crc({8'd0, d}, 120) : 7'h7F;
      e.bits = {2'b00, 6'h3F, d, c, 1'b1};
      e.len  = 136;
    end
    return e;
  endfunction

  function automatic exp_t lit_rsp(input logic [135:0] b, input int len);
    exp_t e;
    e = blank();
    e.kind = K_RSP; e.bits = b; e.len = len;
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit           armed = 0, cap = 0, prev_en = 0;
  int           ncr_cnt = 0, nb = 0;
  logic [135:0] cap_bits = '0;

  task automatic pop_kind(input string nm, input int kind, output exp_t e, output bit ok);
    e = blank();
    ok = 0;
    if (q.size() == 0) begin
      timeout({nm, "_unexpected_event"});
      return;
    end
    e = q.pop_front();
    chk({nm, "_kind"}, 136'(e.kind), 136'(kind));
    ok = (e.kind == kind);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    bit ok;
    if (rst_i) begin
      armed = 0; cap = 0; prev_en = sd_cmd_en_o;
    end else begin
      if (cmd_valid_o && cmd_ready_i) begin
        pop_kind("cmd", K_CMD, e, ok);
        if (ok) begin
          chk("cmd_index", 136'(cmd_index_o), 136'(e.idx));
          chk("cmd_arg", 136'(cmd_arg_o), 136'(e.arg));
        end
      end
      if (cmd_crc_err_o)   pop_kind("crc_err", K_CRC, e, ok);
      if (cmd_frame_err_o) pop_kind("frame_err", K_FRM, e, ok);
      if (sd_cmd_en_o && !prev_en) begin
        chk("tx_expected", 136'(armed), 136'(1));
        chk("ncr_gap", 136'(ncr_cnt), 136'(NCR));
        armed = 0; cap = 1; nb = 0; cap_bits = '0;
      end else if (armed && clk_en_p_i) begin
        ncr_cnt++;
      end
      if (rsp_valid_i && rsp_ready_o && (rsp_type_i == 2'd1 || rsp_type_i == 2'd2)) begin
        armed = 1; ncr_cnt = 0;
      end
      if (cap && sd_cmd_en_o && clk_en_p_i) begin
        if (nb < 136) cap_bits[135 - nb] = sd_cmd_o;
        nb++;
      end
      if (!sd_cmd_en_o && prev_en && cap) begin
        pop_kind("rsp", K_RSP, e, ok);
        if (ok) begin
          chk("rsp_len", 136'(nb), 136'(e.len));
          chk("rsp_bits", cap_bits, e.bits);
        end
        cap = 0;
      end
      prev_en = sd_cmd_en_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_phase(input logic [1:0] k);
    @(posedge clk_i); #1;
    while (phase != k) begin @(posedge clk_i); #1; end
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      wait_phase(2'd2);
      sd_cmd_i = f[i];
    end
    wait_phase(2'd2);
    sd_cmd_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_level(input string nm, input int which, input logic lvl, input int lim);
    int n;
    logic v;
    n = 0;
    v = (which == 0) ? cmd_valid_o : (which == 1) ? rsp_ready_o : sd_cmd_en_o;
    while (v !== lvl && n < lim) begin
      @(posedge clk_i); #1;
      n++;
      v = (which == 0) ? cmd_valid_o : (which == 1) ? rsp_ready_o : sd_cmd_en_o;
    end
    if (v !== lvl) timeout(nm);
  endtask

  // abort >= 0: reset the DUT after that many transmitted bit periods instead of checking the frame
  task automatic do_txn(input logic [47:0] f, input logic [1:0] rt, input logic ce,
                        input logic [5:0] ridx, input logic [119:0] rdata,
                        input bit use_lit, input exp_t lit, input int abort);
    exp_t e;
    e = host_expect(f);
    q.push_back(e);
    send_frame(f);
    if (e.kind != K_CMD) begin
      repeat (8) @(posedge clk_i);
      #1;
      chk("no_valid_after_err", 136'(cmd_valid_o), 136'(0));
      return;
    end
    wait_level("cmd_valid", 0, 1'b1, 100);
    repeat ($urandom_range(0, 3)) @(posedge clk_i);
    #1;
    cmd_ready_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_ready_i = 1'b0;
    wait_level("rsp_ready", 1, 1'b1, 20);
    rsp_type_i = rt; rsp_crc_en_i = ce; rsp_index_i = ridx; rsp_data_i = rdata;
    rsp_valid_i = 1'b1;
    if ((rt == 2'd1 || rt == 2'd2) && abort < 0)
      q.push_back(use_lit ? lit : rsp_expect(rt, ce, ridx, rdata));
    @(posedge clk_i); #1;
    rsp_valid_i = 1'b0;
    if (rt == 2'd1 || rt == 2'd2) begin
      wait_level("tx_start", 2, 1'b1, 8 * NCR + 40);
      if (abort >= 0) begin
        repeat (abort) wait_phase(2'd2);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_en_released", 136'(sd_cmd_en_o), 136'(0));
        chk("rst_line_high", 136'(sd_cmd_o), 136'(1));
        chk("rst_rsp_ready", 136'(rsp_ready_o), 136'(0));
        chk("rst_cmd_valid", 136'(cmd_valid_o), 136'(0));
        rst_i = 1'b0;
      end else begin
        wait_level("tx_end", 2, 1'b0, 4 * 136 + 40);
      end
    end
    repeat (8) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none;
    logic [47:0]  f;
    logic [119:0] d;
    none = blank();
    rst_i = 1'b1; sd_cmd_i = 1'b1; cmd_ready_i = 1'b0; rsp_valid_i = 1'b0;
    rsp_type_i = '0; rsp_crc_en_i = 1'b0; rsp_index_i = '0; rsp_data_i = '0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("reset_line", 136'(sd_cmd_o), 136'(1));
    chk("reset_en", 136'(sd_cmd_en_o), 136'(0));
    chk("reset_valid", 136'(cmd_valid_o), 136'(0));
    chk("reset_rsp_ready", 136'(rsp_ready_o), 136'(0));
    chk("reset_errs", 136'({cmd_crc_err_o, cmd_frame_err_o}), 136'(0));
    chk("reset_index_arg", 136'({cmd_index_o, cmd_arg_o}), 136'(0));
    rst_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;

    // CMD0, no response
    do_txn(48'h40_0000_0000_95, 2'd0, 1'b0, 6'd0, '0, 0, none, -1);
    // CMD8 with R7 response
    do_txn(48'h48_0000_01AA_87, 2'd1, 1'b1, 6'd8, 120'h1AA, 1,
           lit_rsp({48'h08_0000_01AA_13, 88'd0}, 48), -1);
    // corrupted CRC, then a good frame
    do_txn(48'h51_0000_0000_57, 2'd0, 1'b0, 6'd0, '0, 0, none, -1);
    do_txn(48'h51_0000_0000_55, 2'd0, 1'b0, 6'd0, '0, 0, none, -1);
    // transmission bit 0, end bit 0, and both errors together
    do_txn(48'h00_0000_0000_95, 2'd0, 1'b0, 6'd0, '0, 0, none, -1);
    do_txn(48'h40_0000_0000_94, 2'd0, 1'b0, 6'd0, '0, 0, none, -1);
    do_txn(48'h00_0000_0000_94, 2'd0, 1'b0, 6'd0, '0, 0, none, -1);
    // long responses with zero data, CRC on and off
    do_txn(mk_frame(6'd2, 32'h0), 2'd2, 1'b1, 6'd0, 120'h0, 1,
           lit_rsp({2'b00, 6'h3F, 120'h0, 7'h00, 1'b1}, 136), -1);
    do_txn(mk_frame(6'd9, 32'h0), 2'd2, 1'b0, 6'd0, 120'h0, 1,
           lit_rsp({2'b00, 6'h3F, 120'h0, 7'h7F, 1'b1}, 136), -1);
    // reserved response type behaves like none
    do_txn(mk_frame(6'd13, 32'h1234_5678), 2'd3, 1'b1, 6'd13, 120'h55, 0, none, -1);

    for (int k = 0; k < 25; k++) begin
      f = mk_frame(6'($urandom), $urandom);
      case ($urandom_range(0, 9))
        0: f[1 + $urandom_range(0, 6)] ^= 1'b1;
        1: f[46] = 1'b0;
        2: f[0]  = 1'b0;
        default: ;
      endcase
      d = {$urandom, $urandom, $urandom, $urandom};
      do_txn(f, 2'($urandom_range(0, 3)), 1'($urandom), 6'($urandom), d, 0, none, -1);
    end

    // reset in the middle of a response, then a normal CMD0
    do_txn(48'h48_0000_01AA_87, 2'd1, 1'b1, 6'd8, 120'h1AA, 0, none, 20);
    repeat (8) @(posedge clk_i);
    #1;
    do_txn(48'h40_0000_0000_95, 2'd0, 1'b0, 6'd0, '0, 0, none, -1);

    chk("scoreboard_drained", 136'(q.size()), 136'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sd_card_cmd_responder.md
Name: sd_card_cmd_responder

Overview:
Card-side engine for the SD CMD line, the counterpart of the host command sequencer. It deserializes 48-bit host command frames and checks the transmission bit, CRC7 and end bit. Each valid command goes to a card-model/back-end over a valid/ready handshake. The back-end's response (none, 48-bit or 136-bit) is serialized after an NCR gap. Used as a synthesizable card model in FPGA/sim test setups of the SDHCI.

Parameters:
NCR_CYCLES, 2, SD clock periods between the accepted response handshake and the response start bit (legal 2..64).

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
clk_en_p_i  in  1  high in the clk_i cycle before an sd_clk posedge; CMD is sampled only then
clk_en_n_i  in  1  high in the clk_i cycle before an sd_clk negedge; sd_cmd_o/sd_cmd_en_o update only then
sd_cmd_i  in  1  CMD line input
sd_cmd_o  out  1  CMD line drive value
sd_cmd_en_o  out  1  CMD output enable
cmd_valid_o  out  1  received command available
cmd_ready_i  in  1  back-end accepts command
cmd_index_o  out  6  received command index
cmd_arg_o  out  32  received argument
cmd_crc_err_o  out  1  one-cycle pulse: CRC7 mismatch, frame dropped
cmd_frame_err_o  out  1  one-cycle pulse: transmission bit 0 or end bit 0, frame dropped
rsp_valid_i  in  1  response available
rsp_ready_o  out  1  responder accepts response
rsp_type_i  in  2  0 none, 1 short (48), 2 long (136), 3 reserved (treated as none)
rsp_crc_en_i  in  1  1: compute CRC7; 0: send 7'h7F (R3)
rsp_index_i  in  6  index field of a short response
rsp_data_i  in  120  short: [31:0] status; long: CID/CSD[127:8]

Behaviour:
- Reset: state IDLE, sd_cmd_o=1, sd_cmd_en_o=0, cmd_valid_o=0, rsp_ready_o=0, error pulses 0, index/arg 0. Reset mid-frame or mid-transmit aborts immediately; the line is released in the cycle after rst_i is seen.
- All CMD sampling and bit counting advance only on clk_en_p_i. The NCR counter also decrements only on clk_en_p_i.
- IDLE: a sample of 0 starts a frame. CRC7 (x^7+x^3+1, init 0) runs over bits 47..8.
- RX: collect 47 more bits.
  - bit46 must be 1; 0 -> frame error.
  - bits 45:40 are the index; bits 39:8 are the argument; bits 7:1 are the CRC.
  - bit0 must be 1; 0 -> frame error.
- Check on the end-bit sample:
  - Any error: pulse the matching error output for exactly one clk_i cycle and return to IDLE.
  - If both errors occur, only cmd_frame_err_o pulses.
  - Otherwise latch index/arg and go to CMD_OUT.
- CMD_OUT: cmd_valid_o=1 with stable index/arg until cmd_ready_i; then WAIT_RSP. The CMD line is ignored from the end bit until the return to IDLE.
- WAIT_RSP: rsp_ready_o=1.
  - On rsp_valid_i with type none/reserved -> IDLE.
  - On short/long -> latch the frame into the shift register, load the NCR counter with NCR_CYCLES, go to NCR.
- NCR: wait for counter = 0, then go to TX. The first clk_en_n_i in TX sets sd_cmd_en_o=1 and drives the start bit.
- Short frame, 48 bits MSB first: 0, 0, rsp_index_i, rsp_data_i[31:0], CRC7 over the preceding 40 bits (or 7'h7F), 1.
- Long frame, 136 bits: 0, 0, 6'b111111, rsp_data_i[119:0], CRC7 over the 120 data bits only (or 7'h7F), 1.
- Each clk_en_n_i advances one bit. At the clk_en_n_i after the end bit: sd_cmd_o=1, sd_cmd_en_o=0, go to IDLE.
- Host-bit contention is not detected.
- If clk_en_p_i and clk_en_n_i are both high (div-1 mode), sampling and driving both occur in that cycle.

Test Plan:
- Frame 0x40_0000_0000_95 (CMD0, arg 0, CRC 0x4A) -> cmd_valid_o with index 0, arg 0x00000000; no error pulse; rsp_type 0 -> back to IDLE, sd_cmd_en_o never asserted.
- Frame 0x48_0000_01AA_87 (CMD8), back-end responds short, index 8, data 0x1AA, crc_en=1 -> exactly 2 posedges after the handshake the line carries 0x08_0000_01AA_13 MSB first, en high for 48 bit periods then released.
- Frame 0x51_0000_0000_55 with the CRC byte corrupted to 0x57 -> one cmd_crc_err_o pulse, no cmd_valid_o, next good frame accepted.
- Frame with transmission bit 0, then another with end bit 0 -> cmd_frame_err_o pulses once each, state IDLE.
- Long response, data=120'h0, crc_en=1 -> 136 bits: 0, 0, 111111, 120 zeros, CRC7 0x00, 1; crc_en=0 variant -> CRC field 1111111.
- rst_i asserted at bit 20 of a response -> sd_cmd_en_o=0 next cycle, rsp_ready_o=0, a following CMD0 is decoded normally.
